// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encodings and datapath select codes for the main control FSM
package mips_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_SLTI  = 4'b0010;
    localparam logic [3:0] OP_LW    = 4'b0011;
    localparam logic [3:0] OP_SW    = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b0110;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_RWB    = 4'd3,
        S_IEXEC  = 4'd4,
        S_IWB    = 4'd5,
        S_MEMADR = 4'd6,
        S_MEMRD  = 4'd7,
        S_MEMWB  = 4'd8,
        S_MEMWR  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b11;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SLT   = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_OFFSET = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_main_control_if.sv
// rtl/mc_main_control_if.sv - control/datapath/memory signal bundle for the main control FSM
interface mc_main_control_if #(parameter int OPC_W = 4);

    logic [OPC_W-1:0] opcode;
    logic             alu_zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_en;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             instr_done;
    logic             illegal_instr;
    logic [3:0]       state;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_en, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               instr_done, illegal_instr, state
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_en, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               instr_done, illegal_instr, state
    );

endinterface

// File: rtl/mc_perf_counters.sv
// rtl/mc_perf_counters.sv - free-running cycle and retired-instruction counters (MC_PERF_CNT_EN builds only)
module mc_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_instr_done,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_instr_count
);

    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + 1'b1;
            if (i_instr_done) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    assign o_cycle_count = r_cycle_count;
    assign o_instr_count = r_instr_count;

endmodule

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle main control FSM; MC_PERF_CNT_EN adds cycle/instruction counters
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W = 4
`ifdef MC_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic clk,
    input  logic rst,
    mc_main_control_if.master bus
`ifdef MC_PERF_CNT_EN
    , output logic [CNT_W-1:0] cycle_count
    , output logic [CNT_W-1:0] instr_count
`endif
);

    state_t           r_state;
    state_t           w_next;
    logic [OPC_W-1:0] w_opcode;

    assign w_opcode  = bus.opcode;
    assign bus.state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_en         = 1'b0;
        bus.pc_source     = PCSRC_ALU;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REGB;
        bus.alu_op        = ALUOP_RTYPE;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.instr_done    = 1'b0;
        bus.illegal_instr = 1'b0;

        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_ONE;
                bus.alu_op    = ALUOP_ADD;
                bus.pc_source = PCSRC_ALU;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_en    = 1'b1;
                    w_next       = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target so BRANCH can load it from ALUOut.
                bus.alu_src_b = SRCB_OFFSET;
                bus.alu_op    = ALUOP_ADD;
                case (w_opcode)
                    OP_RTYPE:         w_next = S_EXEC;
                    OP_ADDI, OP_SLTI: w_next = S_IEXEC;
                    OP_LW, OP_SW:     w_next = S_MEMADR;
                    OP_BEQ:           w_next = S_BRANCH;
                    OP_J:             w_next = S_JUMP;
                    default: begin
                        bus.illegal_instr = 1'b1;
                        bus.instr_done    = 1'b1;
                        w_next            = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_REGB;
                bus.alu_op    = ALUOP_RTYPE;
                w_next        = S_RWB;
            end
            S_RWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            S_IEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = (w_opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
                w_next        = S_IWB;
            end
            S_IWB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALUOP_ADD;
                w_next        = (w_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    w_next         = S_FETCH;
                end
            end
            S_BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = SRCB_REGB;
                bus.alu_op     = ALUOP_SUB;
                bus.pc_source  = PCSRC_ALUOUT;
                bus.pc_en      = bus.alu_zero;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_source  = PCSRC_JUMP;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset wins over everything so an interrupted instruction commits nothing.
        if (rst) begin
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.pc_en         = 1'b0;
            bus.reg_write     = 1'b0;
            bus.instr_done    = 1'b0;
            bus.illegal_instr = 1'b0;
            w_next            = S_FETCH;
        end
    end

`ifdef MC_PERF_CNT_EN
    mc_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk           (clk),
        .rst           (rst),
        .i_instr_done  (bus.instr_done),
        .o_cycle_count (cycle_count),
        .o_instr_count (instr_count)
    );
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - directed self-checking bench for mc_main_control
module tb_mc_main_control;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    mc_main_control_if #(.OPC_W(4)) bus_if ();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
`endif

    mc_main_control #(
        .OPC_W (4)
`ifdef MC_PERF_CNT_EN
        , .CNT_W (32)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
`ifdef MC_PERF_CNT_EN
        , .cycle_count (cycle_count)
        , .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobes: {mem_read, mem_write, ir_write, pc_en, reg_write, instr_done, illegal_instr}
    localparam logic [6:0] ST_NONE   = 7'b0000000;
    localparam logic [6:0] ST_RDWAIT = 7'b1000000;
    localparam logic [6:0] ST_FRDY   = 7'b1011000;
    localparam logic [6:0] ST_ILL    = 7'b0000011;
    localparam logic [6:0] ST_WB     = 7'b0000110;
    localparam logic [6:0] ST_WRWAIT = 7'b0100000;
    localparam logic [6:0] ST_WRRDY  = 7'b0100010;
    localparam logic [6:0] ST_BRTAK  = 7'b0001010;
    localparam logic [6:0] ST_BRNOT  = 7'b0000010;

    // muxes: {iord, pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg}
    localparam logic [9:0] MX_FETCH  = 10'b0_00_0_01_11_0_0;
    localparam logic [9:0] MX_DECODE = 10'b0_00_0_11_11_0_0;
    localparam logic [9:0] MX_EXEC   = 10'b0_00_1_00_00_0_0;
    localparam logic [9:0] MX_RWB    = 10'b0_00_0_00_00_1_0;
    localparam logic [9:0] MX_IADD   = 10'b0_00_1_10_11_0_0;
    localparam logic [9:0] MX_ISLT   = 10'b0_00_1_10_10_0_0;
    localparam logic [9:0] MX_ZERO   = 10'b0_00_0_00_00_0_0;
    localparam logic [9:0] MX_MEM    = 10'b1_00_0_00_00_0_0;
    localparam logic [9:0] MX_MEMWB  = 10'b0_00_0_00_00_0_1;
    localparam logic [9:0] MX_BRANCH = 10'b0_01_1_00_01_0_0;
    localparam logic [9:0] MX_JUMP   = 10'b0_10_0_00_00_0_0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus_if.mem_read, bus_if.mem_write, bus_if.ir_write, bus_if.pc_en,
                bus_if.reg_write, bus_if.instr_done, bus_if.illegal_instr};
    endfunction

    function automatic logic [9:0] muxes();
        return {bus_if.iord, bus_if.pc_source, bus_if.alu_src_a, bus_if.alu_src_b,
                bus_if.alu_op, bus_if.reg_dst, bus_if.mem_to_reg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] op, input logic mr, input logic az,
                       input logic [3:0] st, input logic [6:0] strb, input logic [9:0] mx);
        bus_if.opcode    = op;
        bus_if.mem_ready = mr;
        bus_if.alu_zero  = az;
        #1;
        chk_eq({tag, ".state"}, 32'(bus_if.state), 32'(st));
        chk_eq({tag, ".strobes"}, 32'(strobes()), 32'(strb));
        chk_eq({tag, ".muxes"}, 32'(muxes()), 32'(mx));
        tick();
    endtask

    task automatic rst_cyc(input string tag, input logic [3:0] st);
        rst              = 1'b1;
        bus_if.mem_ready = 1'b1;
        bus_if.alu_zero  = 1'b1;
        #1;
        chk_eq({tag, ".state"}, 32'(bus_if.state), 32'(st));
        chk_eq({tag, ".strobes"}, 32'(strobes()), 32'(ST_NONE));
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_total          = 0;
        n_bad            = 0;
        rst              = 1'b1;
        bus_if.opcode    = 4'h0;
        bus_if.mem_ready = 1'b0;
        bus_if.alu_zero  = 1'b0;
        tick();
        rst_cyc("init", 4'd0);

        // lw interrupted in MEMRD by a 3-cycle reset
        cyc("lwr_f",  4'h3, 1'b1, 1'b0, 4'd0, ST_FRDY,   MX_FETCH);
        cyc("lwr_d",  4'h3, 1'b0, 1'b0, 4'd1, ST_NONE,   MX_DECODE);
        cyc("lwr_a",  4'h3, 1'b0, 1'b0, 4'd6, ST_NONE,   MX_IADD);
        cyc("lwr_m",  4'h3, 1'b0, 1'b0, 4'd7, ST_RDWAIT, MX_MEM);
        rst = 1'b1;
        rst_cyc("rst1", 4'd7);
        rst = 1'b1;
        rst_cyc("rst2", 4'd0);
        rst = 1'b1;
        rst_cyc("rst3", 4'd0);
        cyc("post_rst", 4'h0, 1'b0, 1'b0, 4'd0, ST_RDWAIT, MX_FETCH);

        // R-type, zero wait; mem_ready asserted outside memory states is ignored
        cyc("r_f",   4'h0, 1'b1, 1'b0, 4'd0, ST_FRDY, MX_FETCH);
        cyc("r_d",   4'h0, 1'b1, 1'b0, 4'd1, ST_NONE, MX_DECODE);
        cyc("r_ex",  4'h0, 1'b1, 1'b0, 4'd2, ST_NONE, MX_EXEC);
        cyc("r_wb",  4'h0, 1'b1, 1'b0, 4'd3, ST_WB,   MX_RWB);

        // lw with two wait cycles in both FETCH and MEMRD: 9 cycles
        cyc("lw_f0", 4'h3, 1'b0, 1'b0, 4'd0, ST_RDWAIT, MX_FETCH);
        cyc("lw_f1", 4'h3, 1'b0, 1'b0, 4'd0, ST_RDWAIT, MX_FETCH);
        cyc("lw_f2", 4'h3, 1'b1, 1'b0, 4'd0, ST_FRDY,   MX_FETCH);
        cyc("lw_d",  4'h3, 1'b0, 1'b0, 4'd1, ST_NONE,   MX_DECODE);
        cyc("lw_a",  4'h3, 1'b0, 1'b0, 4'd6, ST_NONE,   MX_IADD);
        cyc("lw_m0", 4'h3, 1'b0, 1'b0, 4'd7, ST_RDWAIT, MX_MEM);
        cyc("lw_m1", 4'h3, 1'b0, 1'b0, 4'd7, ST_RDWAIT, MX_MEM);
        cyc("lw_m2", 4'h3, 1'b1, 1'b0, 4'd7, ST_RDWAIT, MX_MEM);
        cyc("lw_wb", 4'h3, 1'b0, 1'b0, 4'd8, ST_WB,     MX_MEMWB);

        // beq taken then not taken
        cyc("beq1_f", 4'h5, 1'b1, 1'b1, 4'd0,  ST_FRDY,  MX_FETCH);
        cyc("beq1_d", 4'h5, 1'b0, 1'b1, 4'd1,  ST_NONE,  MX_DECODE);
        cyc("beq1_b", 4'h5, 1'b0, 1'b1, 4'd10, ST_BRTAK, MX_BRANCH);
        cyc("beq0_f", 4'h5, 1'b1, 1'b0, 4'd0,  ST_FRDY,  MX_FETCH);
        cyc("beq0_d", 4'h5, 1'b0, 1'b0, 4'd1,  ST_NONE,  MX_DECODE);
        cyc("beq0_b", 4'h5, 1'b0, 1'b0, 4'd10, ST_BRNOT, MX_BRANCH);

        // slti then addi
        cyc("slti_f", 4'h2, 1'b1, 1'b0, 4'd0, ST_FRDY, MX_FETCH);
        cyc("slti_d", 4'h2, 1'b0, 1'b0, 4'd1, ST_NONE, MX_DECODE);
        cyc("slti_x", 4'h2, 1'b0, 1'b0, 4'd4, ST_NONE, MX_ISLT);
        cyc("slti_w", 4'h2, 1'b0, 1'b0, 4'd5, ST_WB,   MX_ZERO);
        cyc("addi_f", 4'h1, 1'b1, 1'b0, 4'd0, ST_FRDY, MX_FETCH);
        cyc("addi_d", 4'h1, 1'b0, 1'b0, 4'd1, ST_NONE, MX_DECODE);
        cyc("addi_x", 4'h1, 1'b0, 1'b0, 4'd4, ST_NONE, MX_IADD);
        cyc("addi_w", 4'h1, 1'b0, 1'b0, 4'd5, ST_WB,   MX_ZERO);

        // sw with one write wait, then j
        cyc("sw_f",  4'h4, 1'b1, 1'b0, 4'd0, ST_FRDY,   MX_FETCH);
        cyc("sw_d",  4'h4, 1'b0, 1'b0, 4'd1, ST_NONE,   MX_DECODE);
        cyc("sw_a",  4'h4, 1'b0, 1'b0, 4'd6, ST_NONE,   MX_IADD);
        cyc("sw_w0", 4'h4, 1'b0, 1'b0, 4'd9, ST_WRWAIT, MX_MEM);
        cyc("sw_w1", 4'h4, 1'b1, 1'b0, 4'd9, ST_WRRDY,  MX_MEM);
        cyc("j_f",   4'h6, 1'b1, 1'b0, 4'd0,  ST_FRDY,  MX_FETCH);
        cyc("j_d",   4'h6, 1'b0, 1'b0, 4'd1,  ST_NONE,  MX_DECODE);
        cyc("j_j",   4'h6, 1'b0, 1'b0, 4'd11, ST_BRTAK, MX_JUMP);

        // illegal opcode right after a fresh reset
        rst = 1'b1;
        rst_cyc("ill_rst", 4'd0);
        cyc("ill_f", 4'hF, 1'b1, 1'b0, 4'd0, ST_FRDY, MX_FETCH);
        cyc("ill_d", 4'hF, 1'b0, 1'b0, 4'd1, ST_ILL,  MX_DECODE);
`ifdef MC_PERF_CNT_EN
        chk_eq("perf.cycle_count", cycle_count, 32'd2);
        chk_eq("perf.instr_count", instr_count, 32'd1);
`endif
        cyc("ill_ret", 4'h0, 1'b0, 1'b0, 4'd0, ST_RDWAIT, MX_FETCH);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
